// File: rtl/io_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : io_out_buffer
// Description : CPU output FIFO (first-word-fall-through) with halt-driven drain.
// Revision    : 1.0 - initial release
// ============================================================================
module io_out_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     out_signal,
    input  logic [WIDTH-1:0]         out_data,
    input  logic                     halt,
    output logic                     tx_valid,
    output logic [WIDTH-1:0]         tx_data,
    input  logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     drained
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;

    logic             w_accept;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [CW-1:0]    w_remain;

    assign w_full = (count_q == CW'(DEPTH));
    assign w_pop  = (count_q != '0) && tx_ready;
    assign w_push = out_signal && w_accept && (!w_full || w_pop);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (halt) state_d = ST_DRAIN;
            ST_DRAIN: if (count_d == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_accept = (state_q == ST_RUN);
        drained  = (state_q == ST_DONE);
    end

    // Datapath next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q + AW'(w_push);
        rd_ptr_d   = rd_ptr_q + AW'(w_pop);
        count_d    = count_q + CW'(w_push) - CW'(w_pop);
        overflow_d = overflow_q | (out_signal && w_accept && w_full && !w_pop);
        w_remain   = count_q - CW'(w_pop);
        tx_data_d  = tx_data_q;
        // Head after this edge: an older stored word, or the incoming one if nothing older remains
        if (w_remain != '0) begin
            tx_data_d = mem_q[rd_ptr_d];
        end else if (w_push) begin
            tx_data_d = out_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Storage is intentionally not cleared on reset
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            mem_q[wr_ptr_q] <= out_data;
        end
    end

    assign tx_valid = (count_q != '0);
    assign tx_data  = tx_data_q;
    assign count    = count_q;
    assign full     = w_full;
    assign empty    = (count_q == '0);
    assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_io_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_out_buffer
// Description : Directed vector table plus hand sequences for io_out_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_out_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        out_signal;
    logic [63:0] out_data;
    logic        halt;
    logic        tx_valid;
    logic [63:0] tx_data;
    logic        tx_ready;
    logic [3:0]  count;
    logic        full, empty, overflow, drained;

    int total = 0;
    int bad   = 0;
    logic [63:0] rx[$];

    always #5 clk = ~clk;

    io_out_buffer #(.DEPTH(8), .WIDTH(64)) dut (
        .clk(clk), .reset(reset), .out_signal(out_signal), .out_data(out_data),
        .halt(halt), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .count(count), .full(full), .empty(empty), .overflow(overflow), .drained(drained)
    );

    typedef struct {
        logic        rst_n;
        logic        os;
        logic [63:0] od;
        logic        hlt;
        logic        rdy;
        logic        e_valid;
        logic        e_chkd;
        logic [63:0] e_data;
        logic [3:0]  e_count;
        logic        e_ovf;
        logic        e_drn;
    } vec_t;

    localparam int NV = 14;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        out_signal = 1'b0;
        out_data   = '0;
        halt       = 1'b0;
        tx_ready   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic push(input logic [63:0] d);
        out_signal = 1'b1;
        out_data   = d;
        tick();
        out_signal = 1'b0;
    endtask

    task automatic drain_collect(input int maxc);
        rx.delete();
        tx_ready = 1'b1;
        for (int c = 0; c < maxc && tx_valid; c++) begin
            rx.push_back(tx_data);
            tick();
        end
        tx_ready = 1'b0;
    endtask

    function automatic vec_t mk(logic r, logic os, logic [63:0] od, logic h, logic rdy,
                                logic v, logic cd, logic [63:0] d, logic [3:0] c,
                                logic ov, logic dr);
        vec_t t;
        t.rst_n = r; t.os = os; t.od = od; t.hlt = h; t.rdy = rdy;
        t.e_valid = v; t.e_chkd = cd; t.e_data = d; t.e_count = c;
        t.e_ovf = ov; t.e_drn = dr;
        return t;
    endfunction

    initial begin
        //            rst os  od     h  rdy   v  chkd data   cnt ovf drn
        vt[0]  = mk(0, 0, 64'h0,  0, 0,   0, 1, 64'h0,  0, 0, 0);
        vt[1]  = mk(1, 0, 64'h0,  0, 0,   0, 1, 64'h0,  0, 0, 0);
        vt[2]  = mk(1, 1, 64'hA5, 0, 0,   1, 1, 64'hA5, 1, 0, 0);
        vt[3]  = mk(1, 0, 64'h0,  0, 0,   1, 1, 64'hA5, 1, 0, 0);
        vt[4]  = mk(1, 0, 64'h0,  0, 0,   1, 1, 64'hA5, 1, 0, 0);
        vt[5]  = mk(1, 0, 64'h0,  0, 0,   1, 1, 64'hA5, 1, 0, 0);
        vt[6]  = mk(1, 0, 64'h0,  0, 0,   1, 1, 64'hA5, 1, 0, 0);
        vt[7]  = mk(1, 0, 64'h0,  0, 0,   1, 1, 64'hA5, 1, 0, 0);
        vt[8]  = mk(1, 0, 64'h0,  0, 1,   0, 0, 64'h0,  0, 0, 0);
        vt[9]  = mk(1, 1, 64'h11, 0, 1,   1, 1, 64'h11, 1, 0, 0);
        vt[10] = mk(1, 1, 64'h22, 0, 1,   1, 1, 64'h22, 1, 0, 0);
        vt[11] = mk(1, 1, 64'h33, 0, 0,   1, 1, 64'h22, 2, 0, 0);
        vt[12] = mk(1, 0, 64'h0,  0, 1,   1, 1, 64'h33, 1, 0, 0);
        vt[13] = mk(1, 0, 64'h0,  0, 1,   0, 0, 64'h0,  0, 0, 0);

        idle_inputs();
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            reset      = vt[i].rst_n;
            out_signal = vt[i].os;
            out_data   = vt[i].od;
            halt       = vt[i].hlt;
            tx_ready   = vt[i].rdy;
            tick();
            chk($sformatf("v%0d.tx_valid", i), tx_valid, vt[i].e_valid);
            if (vt[i].e_chkd) chk($sformatf("v%0d.tx_data", i), tx_data, vt[i].e_data);
            chk($sformatf("v%0d.count", i), count, vt[i].e_count);
            chk($sformatf("v%0d.full", i), full, vt[i].e_count == 4'd8);
            chk($sformatf("v%0d.empty", i), empty, vt[i].e_count == 4'd0);
            chk($sformatf("v%0d.overflow", i), overflow, vt[i].e_ovf);
            chk($sformatf("v%0d.drained", i), drained, vt[i].e_drn);
        end

        // Fill past capacity: word 9 must be dropped
        do_reset();
        for (int i = 1; i <= 9; i++) push(64'(i));
        chk("fill.count", count, 4'd8);
        chk("fill.full", full, 1'b1);
        chk("fill.overflow", overflow, 1'b1);
        drain_collect(20);
        chk("fill.rxlen", rx.size(), 8);
        for (int i = 0; i < rx.size() && i < 8; i++) chk($sformatf("fill.rx%0d", i), rx[i], 64'(i + 1));
        chk("fill.overflow_sticky", overflow, 1'b1);

        // Full with same-edge pop
        do_reset();
        for (int i = 1; i <= 8; i++) push(64'(i));
        out_signal = 1'b1; out_data = 64'h55; tx_ready = 1'b1;
        tick();
        idle_inputs();
        chk("fullpop.count", count, 4'd8);
        chk("fullpop.overflow", overflow, 1'b0);
        drain_collect(20);
        chk("fullpop.rxlen", rx.size(), 8);
        for (int i = 0; i < rx.size() && i < 8; i++)
            chk($sformatf("fullpop.rx%0d", i), rx[i], (i == 7) ? 64'h55 : 64'(i + 2));

        // Wrap: producer respects full, sink toggles ready
        do_reset();
        begin
            int sent = 0;
            int cyc  = 0;
            rx.delete();
            while ((sent < 20 || tx_valid) && cyc < 300) begin
                out_signal = (sent < 20) && !full;
                out_data   = 64'(100 + sent);
                tx_ready   = cyc[0];
                if (tx_valid && tx_ready) rx.push_back(tx_data);
                tick();
                if (out_signal) sent++;
                cyc++;
            end
            idle_inputs();
            chk("wrap.timeout", cyc < 300, 1'b1);
        end
        chk("wrap.rxlen", rx.size(), 20);
        for (int i = 0; i < rx.size() && i < 20; i++) chk($sformatf("wrap.rx%0d", i), rx[i], 64'(100 + i));
        chk("wrap.overflow", overflow, 1'b0);

        // Drain: push accepted on the halt edge, later writes ignored
        do_reset();
        push(64'h31); push(64'h32); push(64'h33);
        halt = 1'b1; out_signal = 1'b1; out_data = 64'h34;
        tick();
        halt = 1'b0; out_data = 64'h99;
        chk("drain.count_halt", count, 4'd4);
        tick(); tick();
        chk("drain.count_ignored", count, 4'd4);
        chk("drain.overflow", overflow, 1'b0);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain.data%0d", i), tx_data, 64'h31 + 64'(i));
            tick();
            chk($sformatf("drain.count%0d", i), count, 4'(3 - i));
            chk($sformatf("drain.drained%0d", i), drained, i == 3);
        end
        tick();
        chk("drain.done_persist", drained, 1'b1);
        chk("drain.empty", empty, 1'b1);
        idle_inputs();

        // Reset mid-drain with overflow set
        do_reset();
        for (int i = 1; i <= 9; i++) push(64'(i));
        tx_ready = 1'b1;
        repeat (5) tick();
        tx_ready = 1'b0;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("rst.pre_count", count, 4'd3);
        chk("rst.pre_overflow", overflow, 1'b1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rst.count", count, 4'd0);
        chk("rst.tx_valid", tx_valid, 1'b0);
        chk("rst.overflow", overflow, 1'b0);
        chk("rst.drained", drained, 1'b0);
        chk("rst.tx_data", tx_data, 64'h0);
        push(64'h77);
        chk("rst.run_count", count, 4'd1);
        chk("rst.run_data", tx_data, 64'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_out_buffer.md
IO_OUT_BUFFER -- requirements
Module: io_out_buffer

Interface
REQ-001 Parameter: DEPTH, 8, FIFO entries; SHALL be a power of two, ≥2.
REQ-002 Parameter: WIDTH, 64, data word width.
REQ-003 Port: clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-004 Port: reset  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 Port: out_signal  input  1  CPU output-present strobe; each high cycle SHALL be one write request.
REQ-006 Port: out_data  input  WIDTH  CPU output word, sampled when out_signal=1.
REQ-007 Port: halt  input  1  CPU halt indication; starts drain.
REQ-008 Port: tx_valid  output  1  head word available to the sink.
REQ-009 Port: tx_data  output  WIDTH  head word.
REQ-010 Port: tx_ready  input  1  sink accepts the head word.
REQ-011 Port: count  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 Port: full  output  1  count==DEPTH.
REQ-013 Port: empty  output  1  count==0.
REQ-014 Port: overflow  output  1  sticky, set when a write is dropped while full.
REQ-015 Port: drained  output  1  halt seen and all words delivered.

Function
REQ-016 Storage SHALL be a DEPTH x WIDTH circular buffer with read/write pointers wrapping modulo DEPTH.
REQ-017 Pop SHALL occur on an edge where tx_valid=1 and tx_ready=1; rd_ptr advances and count decrements.
REQ-018 Push SHALL occur on an edge where out_signal=1, state=RUN, and (full=0 or a pop occurs that same edge).
REQ-019 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-020 Push when full with no same-edge pop SHALL discard the word, leave storage and pointers unchanged, and set overflow=1.
REQ-021 overflow SHALL remain 1 until reset.
REQ-022 tx_valid SHALL equal ~empty; tx_data SHALL equal the entry at rd_ptr (first-word-fall-through), registered, no input-to-output bypass.
REQ-023 Latency: a word pushed at edge k SHALL be visible on tx_data with tx_valid=1 from edge k onward when the FIFO was empty (one-cycle write-to-valid latency).
REQ-024 While tx_valid=1 and tx_ready=0, tx_data and tx_valid SHALL hold stable.
REQ-025 FSM states: RUN, DRAIN, DONE.
REQ-026 RUN -> DRAIN on an edge with halt=1; a push requested on that same edge SHALL still be accepted.
REQ-027 In DRAIN and DONE, out_signal SHALL be ignored (no push, no overflow change).
REQ-028 DRAIN -> DONE on the edge where count becomes 0, or at the first edge in DRAIN when count is already 0.
REQ-029 drained SHALL be 1 exactly when state=DONE; DONE SHALL persist until reset.
REQ-030 Pops SHALL continue normally in DRAIN.
REQ-031 tx_ready with tx_valid=0 SHALL have no effect.

Reset
REQ-032 reset=0 at a posedge SHALL set state=RUN, pointers=0, count=0, empty=1, full=0, tx_valid=0, overflow=0, drained=0, overriding any same-edge push or pop.
REQ-033 tx_data SHALL be 0 after reset; storage contents need not be cleared.
REQ-034 reset asserted mid-drain or mid-transfer SHALL discard all buffered words.

Verification
REQ-035 Single word: out_signal pulse with out_data=0xA5 into empty FIFO, tx_ready=0 -> next cycle tx_valid=1, tx_data=0xA5, count=1; hold 5 cycles stable; tx_ready=1 one cycle -> empty=1.
REQ-036 Fill/overflow: 9 pushes of 1..9, tx_ready=0 -> full=1, count=8, overflow=1, then draining yields 1..8 in order, word 9 absent.
REQ-037 Full with simultaneous pop: full, out_signal=1 (data 0x55) and tx_ready=1 same edge -> count stays 8, overflow=0, 0x55 emerges last.
REQ-038 Wrap: 20 words streamed with tx_ready toggling 1/0 every cycle -> all 20 received in order, no loss, overflow=0.
REQ-039 Drain: 3 words buffered, halt=1 with out_signal=1 same edge -> 4 words buffered; later out_signal ignored; drained=1 on the edge count reaches 0.
REQ-040 Reset mid-drain: reset=0 with count=3 in DRAIN -> next cycle count=0, state=RUN, drained=0, overflow=0, tx_valid=0.
